// File: rtl/rpn_display_if.sv
// Request/status handshake between the calculator datapath and the display back end.
interface rpn_display_if;
  logic       start;
  logic [7:0] value;
  logic       signed_mode;
  logic       err;
  logic       busy;
  logic       done;

  modport master (output start, value, signed_mode, err, input  busy, done);
  modport slave  (input  start, value, signed_mode, err, output busy, done);
endinterface

// File: rtl/rpn_display.sv
// Display back end: serial double-dabble of an 8-bit stack top onto six active-low 7-seg digits.
// States: S_IDLE wait for start | S_CONVERT one shift/add-3 per cycle | S_UPDATE load HEX registers
module rpn_display (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  rpn_display_if.slave bus,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX3,
  output logic [6:0]   HEX4,
  output logic [6:0]   HEX5
);
  localparam logic [6:0] G_OFF   = 7'b1111111;
  localparam logic [6:0] G_ZERO  = 7'b1000000;
  localparam logic [6:0] G_MINUS = 7'b0111111;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_R     = 7'b0101111;
  localparam logic [6:0] G_O     = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_UPDATE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [11:0]      bcd_q, bcd_d, bcd_adj;
  logic [7:0]       mag_q, mag_d;
  logic             neg_q, neg_d, err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [5:0][6:0]  hex_q, hex_d;
  logic [19:0]      shifted;
  logic             neg_in;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0011000;
      default: seg7 = G_OFF;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hex_q   <= {G_OFF, G_OFF, G_OFF, G_OFF, G_OFF, G_ZERO};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = bus.err ? S_UPDATE : S_CONVERT;
      S_CONVERT: if (cnt_q == 3'd7) state_d = S_UPDATE;
      S_UPDATE:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    err_d   = err_q;
    hex_d   = hex_q;
    neg_in  = bus.signed_mode & bus.value[7];
    bcd_adj = bcd_q;
    shifted = '0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        err_d = bus.err;
        neg_d = neg_in;
        mag_d = neg_in ? (~bus.value + 8'd1) : bus.value;
        bcd_d = '0;
        cnt_d = '0;
      end
      S_CONVERT: begin
        for (int i = 0; i < 3; i++)
          if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        shifted = {bcd_adj, mag_q} << 1;
        bcd_d   = shifted[19:8];
        mag_d   = shifted[7:0];
        cnt_d   = cnt_q + 3'd1;
      end
      S_UPDATE: begin
        if (err_q) begin
          hex_d = {G_OFF, G_E, G_R, G_R, G_O, G_R};
        end else begin
          hex_d[0] = seg7(bcd_q[3:0]);
          hex_d[1] = (bcd_q[11:4] == 8'd0) ? G_OFF : seg7(bcd_q[7:4]);
          hex_d[2] = (bcd_q[11:8] == 4'd0) ? G_OFF : seg7(bcd_q[11:8]);
          hex_d[3] = neg_q ? G_MINUS : G_OFF;
          hex_d[4] = G_OFF;
          hex_d[5] = G_OFF;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_UPDATE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
endmodule
